sad_accum_ctrl: RTL and testbench

SAD_ACCUM_CTRL -- requirements
Module: sad_accum_ctrl

---
 rtl/sad_accum_ctrl_pkg.sv | 28 ++
 rtl/sad_accum_ctrl_add8.sv | 32 +++
 rtl/sad_accum_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sad_accum_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_accum_ctrl_pkg.sv
// Shared motion-estimation definitions: SAD controller state encoding and
// width helpers used by the controller and its adder tree.
package sad_accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } sad_state_e;

  localparam int unsigned ADD_INPUTS = 8;

  // A candidate sum grows by log2(ROWS) bits over its per-row width.
  function automatic int unsigned sad_width(input int unsigned elem_w, input int unsigned rows);
    return elem_w + $clog2(rows);
  endfunction

  function automatic int unsigned idx_width(input int unsigned cands);
    return $clog2(cands);
  endfunction

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_accum_ctrl_add8.sv
// ADD_8 adder tree: sums eight packed elements, result wraps modulo
// 2^ELEMENT_BIT_DEPTH (every level is kept at element width).
module sad_accum_ctrl_add8
  import sad_accum_ctrl_pkg::*;
#(
  parameter int unsigned ELEMENT_BIT_DEPTH = 14
) (
  input  logic [ELEMENT_BIT_DEPTH*ADD_INPUTS-1:0] elems_i,
  output logic [ELEMENT_BIT_DEPTH-1:0]            sum_o
);

  localparam int unsigned W = ELEMENT_BIT_DEPTH;

  logic [W-1:0] lvl0 [ADD_INPUTS];
  logic [W-1:0] lvl1 [ADD_INPUTS/2];
  logic [W-1:0] lvl2 [ADD_INPUTS/4];

  // Three balanced levels; truncation at each level equals truncating the total.
  always_comb begin
    for (int i = 0; i < ADD_INPUTS; i++) begin
      lvl0[i] = elems_i[i*W +: W];
    end
    for (int i = 0; i < ADD_INPUTS/2; i++) begin
      lvl1[i] = W'(lvl0[2*i] + lvl0[2*i+1]);
    end
    for (int i = 0; i < ADD_INPUTS/4; i++) begin
      lvl2[i] = W'(lvl1[2*i] + lvl1[2*i+1]);
    end
    sum_o = W'(lvl2[0] + lvl2[1]);
  end

endmodule

// File: rtl/sad_accum_ctrl.sv
// SAD accumulation controller: sums ROWS rows of absolute differences per
// candidate, reports each candidate's SAD and tracks the minimum over a search.
module sad_accum_ctrl
  import sad_accum_ctrl_pkg::*;
#(
  parameter int unsigned ELEMENT_BIT_DEPTH = 14,
  parameter int unsigned ROWS              = 8,
  parameter int unsigned CANDIDATES        = 16,
  localparam int unsigned SAD_W            = sad_width(ELEMENT_BIT_DEPTH, ROWS),
  localparam int unsigned IDX_W            = idx_width(CANDIDATES)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    ad_valid,
  output logic                                    ad_ready,
  input  logic [ELEMENT_BIT_DEPTH*ADD_INPUTS-1:0] ad_array,
  output logic                                    sad_valid,
  output logic [SAD_W-1:0]                        sad,
  output logic [IDX_W-1:0]                        sad_idx,
  output logic [SAD_W-1:0]                        best_sad,
  output logic [IDX_W-1:0]                        best_idx,
  output logic                                    done,
  output logic                                    busy
);

  localparam int unsigned RCNT_W = cnt_width(ROWS);

  sad_state_e                   state_q;
  logic [SAD_W-1:0]             acc_q;
  logic [RCNT_W-1:0]            row_cnt_q;
  logic [IDX_W-1:0]             cand_cnt_q;
  logic [SAD_W-1:0]             min_q;
  logic [IDX_W-1:0]             min_idx_q;
  logic                         ad_ready_q;
  logic                         sad_valid_q;
  logic [SAD_W-1:0]             sad_q;
  logic [IDX_W-1:0]             sad_idx_q;
  logic [SAD_W-1:0]             best_sad_q;
  logic [IDX_W-1:0]             best_idx_q;
  logic                         done_q;
  logic                         busy_q;

  logic [ELEMENT_BIT_DEPTH-1:0] row_sum_c;
  logic [SAD_W-1:0]             acc_d;
  logic                         accept_c;
  logic                         last_row_c;
  logic                         last_cand_c;
  logic                         better_c;
  logic [SAD_W-1:0]             min_d;
  logic [IDX_W-1:0]             min_idx_d;

  sad_accum_ctrl_add8 #(
    .ELEMENT_BIT_DEPTH(ELEMENT_BIT_DEPTH)
  ) u_add8 (
    .elems_i(ad_array),
    .sum_o  (row_sum_c)
  );

  assign accept_c    = ad_valid && ad_ready_q;
  assign acc_d       = acc_q + SAD_W'(row_sum_c);
  assign last_row_c  = (row_cnt_q == RCNT_W'(ROWS - 1));
  assign last_cand_c = (cand_cnt_q == IDX_W'(CANDIDATES - 1));

  // Strict compare: on a tie the earlier (lower-index) candidate is kept.
  assign better_c  = (acc_q < min_q);
  assign min_d     = better_c ? acc_q : min_q;
  assign min_idx_d = better_c ? cand_cnt_q : min_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      min_q       <= '0;
      min_idx_q   <= '0;
      ad_ready_q  <= 1'b0;
      sad_valid_q <= 1'b0;
      sad_q       <= '0;
      sad_idx_q   <= '0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            row_cnt_q  <= '0;
            cand_cnt_q <= '0;
            min_q      <= '1;
            min_idx_q  <= '0;
            ad_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        // Outputs for EMIT are registered on the final accept so they appear in EMIT.
        ST_ACCUM: begin
          if (accept_c) begin
            acc_q     <= acc_d;
            row_cnt_q <= row_cnt_q + RCNT_W'(1);
            if (last_row_c) begin
              state_q     <= ST_EMIT;
              ad_ready_q  <= 1'b0;
              sad_valid_q <= 1'b1;
              sad_q       <= acc_d;
              sad_idx_q   <= cand_cnt_q;
            end
          end
        end

        ST_EMIT: begin
          sad_valid_q <= 1'b0;
          min_q       <= min_d;
          min_idx_q   <= min_idx_d;
          acc_q       <= '0;
          row_cnt_q   <= '0;
          if (last_cand_c) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            best_sad_q <= min_d;
            best_idx_q <= min_idx_d;
          end else begin
            state_q    <= ST_ACCUM;
            cand_cnt_q <= cand_cnt_q + IDX_W'(1);
            ad_ready_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          ad_ready_q  <= 1'b0;
          sad_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ad_ready  = ad_ready_q;
  assign sad_valid = sad_valid_q;
  assign sad       = sad_q;
  assign sad_idx   = sad_idx_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sad_accum_ctrl.sv
// Bench for sad_accum_ctrl: directed vector table, random searches against a
// plain-arithmetic SAD model, plus reset-abort and start-while-busy sequences.
module tb_sad_accum_ctrl;

  localparam int unsigned EBD    = 14;
  localparam int unsigned ROWS   = 8;
  localparam int unsigned CANDS  = 4;
  localparam int unsigned SAD_W  = 17;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NROWS  = CANDS * ROWS;
  localparam int          NVEC   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               ad_valid = 1'b0;
  logic [EBD*8-1:0]   ad_array = '0;
  logic               ad_ready;
  logic               sad_valid;
  logic [SAD_W-1:0]   sad;
  logic [IDX_W-1:0]   sad_idx;
  logic [SAD_W-1:0]   best_sad;
  logic [IDX_W-1:0]   best_idx;
  logic               done;
  logic               busy;

  sad_accum_ctrl #(
    .ELEMENT_BIT_DEPTH(EBD),
    .ROWS             (ROWS),
    .CANDIDATES       (CANDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ad_valid (ad_valid),
    .ad_ready (ad_ready),
    .ad_array (ad_array),
    .sad_valid(sad_valid),
    .sad      (sad),
    .sad_idx  (sad_idx),
    .best_sad (best_sad),
    .best_idx (best_idx),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned val[CANDS];
    int          mode;
    bit          poke;
    int unsigned exp_sad[CANDS];
    int unsigned exp_best;
    int unsigned exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[NVEC];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned elem_q[NROWS][8];
  int unsigned got_sad[$];
  int unsigned got_idx[$];
  int          done_cyc;
  bit          done_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EBD*8-1:0] pack_row(input int r);
    logic [EBD*8-1:0] v;
    v = '0;
    for (int e = 0; e < 8; e++) v[e*EBD +: EBD] = EBD'(elem_q[r][e]);
    return v;
  endfunction

  // Reference: row sums wrap at 2^14, candidate sums wrap at 2^17.
  function automatic int unsigned model_sad(input int c);
    int unsigned s, rs;
    s = 0;
    for (int r = 0; r < ROWS; r++) begin
      rs = 0;
      for (int e = 0; e < 8; e++) rs += elem_q[c*ROWS + r][e];
      s += rs % (1 << EBD);
    end
    return s % (1 << SAD_W);
  endfunction

  task automatic fill_const(input int unsigned v0, input int unsigned v1,
                            input int unsigned v2, input int unsigned v3);
    int unsigned v[CANDS];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int c = 0; c < CANDS; c++)
      for (int r = 0; r < ROWS; r++)
        for (int e = 0; e < 8; e++) elem_q[c*ROWS + r][e] = v[c];
  endtask

  task automatic set_vec(input int i, input int unsigned v0, input int unsigned v1,
                         input int unsigned v2, input int unsigned v3, input int mode,
                         input bit poke, input int unsigned s0, input int unsigned s1,
                         input int unsigned s2, input int unsigned s3, input int unsigned b,
                         input int unsigned bi, input int lat);
    vecs[i].val[0] = v0; vecs[i].val[1] = v1; vecs[i].val[2] = v2; vecs[i].val[3] = v3;
    vecs[i].mode = mode;
    vecs[i].poke = poke;
    vecs[i].exp_sad[0] = s0; vecs[i].exp_sad[1] = s1;
    vecs[i].exp_sad[2] = s2; vecs[i].exp_sad[3] = s3;
    vecs[i].exp_best = b;
    vecs[i].exp_idx  = bi;
    vecs[i].exp_lat  = lat;
  endtask

  // mode 0: ad_valid always high; 1: every other cycle; 2: random gaps.
  task automatic run_search(input int mode, input bit poke);
    int row_ptr;
    int cyc;
    bit want;
    bit acc;
    got_sad.delete();
    got_idx.delete();
    done_seen = 1'b0;
    done_cyc  = -1;
    row_ptr   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 1000) begin
      if (sad_valid) begin
        got_sad.push_back(32'(sad));
        got_idx.push_back(32'(sad_idx));
        check("ad_ready_low_in_emit", 32'(ad_ready), 32'd0);
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        break;
      end
      case (mode)
        0:       want = 1'b1;
        1:       want = (cyc % 2) == 0;
        default: want = ($urandom_range(0, 2) != 0);
      endcase
      if (want && row_ptr < NROWS) begin
        ad_valid = 1'b1;
        ad_array = pack_row(row_ptr);
      end else begin
        ad_valid = 1'b0;
      end
      acc = ad_valid && ad_ready;
      if (poke) start = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
      if (acc) row_ptr++;
    end
    ad_valid = 1'b0;
    start    = 1'b0;
    check("done_within_budget", 32'(done_seen), 32'd1);
    if (done_seen) begin
      if (poke) start = 1'b1;
      step();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      check("rows_consumed", 32'(row_ptr), 32'(NROWS));
    end
  endtask

  task automatic check_results(input string tag, input int unsigned es[CANDS],
                               input int unsigned eb, input int unsigned ei, input int elat);
    check({tag, "_sad_count"}, 32'(got_sad.size()), 32'(CANDS));
    for (int c = 0; c < CANDS; c++) begin
      if (c < got_sad.size()) begin
        check($sformatf("%s_sad%0d", tag, c), 32'(got_sad[c]), 32'(es[c]));
        check($sformatf("%s_sad_idx%0d", tag, c), 32'(got_idx[c]), 32'(c));
      end
    end
    check({tag, "_best_sad"}, 32'(best_sad), 32'(eb));
    check({tag, "_best_idx"}, 32'(best_idx), 32'(ei));
    if (elat > 0) check({tag, "_start_to_done"}, 32'(done_cyc), 32'(elat));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_ad_ready"},  32'(ad_ready),  32'd0);
    check({tag, "_sad_valid"}, 32'(sad_valid), 32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_sad"},       32'(sad),       32'd0);
    check({tag, "_sad_idx"},   32'(sad_idx),   32'd0);
    check({tag, "_best_sad"},  32'(best_sad),  32'd0);
    check({tag, "_best_idx"},  32'(best_idx),  32'd0);
  endtask

  initial begin
    int unsigned es[CANDS];
    int unsigned eb, ei, lim;
    int row_ptr, guard;
    bit acc;

    set_vec(0, 1, 1, 1, 1,             0, 1'b0,  64,  64,  64,  64,  64, 0, 37);
    set_vec(1, 3, 3, 0, 3,             0, 1'b0, 192, 192,   0, 192,   0, 2, 37);
    set_vec(2, 3, 3, 0, 3,             1, 1'b0, 192, 192,   0, 192,   0, 2, -1);
    set_vec(3, 16383, 16383, 16383, 16383, 0, 1'b0, 131008, 131008, 131008, 131008, 131008, 0, 37);
    set_vec(4, 3, 3, 0, 3,             0, 1'b1, 192, 192,   0, 192,   0, 2, 37);

    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      fill_const(vecs[i].val[0], vecs[i].val[1], vecs[i].val[2], vecs[i].val[3]);
      run_search(vecs[i].mode, vecs[i].poke);
      check_results($sformatf("vec%0d", i), vecs[i].exp_sad, vecs[i].exp_best,
                    vecs[i].exp_idx, vecs[i].exp_lat);
      step();
    end

    // Random searches; small-value ranges make equal SADs (tie handling) likely.
    for (int t = 0; t < 6; t++) begin
      lim = (t % 2 == 0) ? 32'd16383 : 32'd1;
      for (int r = 0; r < NROWS; r++)
        for (int e = 0; e < 8; e++) elem_q[r][e] = $urandom_range(0, lim);
      eb = 32'hFFFF_FFFF;
      ei = 0;
      for (int c = 0; c < CANDS; c++) begin
        es[c] = model_sad(c);
        if (es[c] < eb) begin
          eb = es[c];
          ei = c;
        end
      end
      run_search(t % 3, t >= 3);
      check_results($sformatf("rand%0d", t), es, eb, ei, (t % 3 == 0) ? 37 : -1);
    end

    // Abort a search with reset after three rows of candidate 1.
    fill_const(1, 1, 1, 1);
    start = 1'b1;
    step();
    start    = 1'b0;
    ad_valid = 1'b1;
    row_ptr  = 0;
    guard    = 0;
    while (row_ptr < ROWS + 3 && guard < 100) begin
      ad_array = pack_row(row_ptr);
      acc = ad_ready;
      step();
      if (acc) row_ptr++;
      guard++;
    end
    check("abort_rows_fed", 32'(row_ptr), 32'(ROWS + 3));
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst      = 1'b0;
    start    = 1'b0;
    ad_valid = 1'b0;
    check_all_zero("abort");
    step();
    check("abort_start_dropped", 32'(busy), 32'd0);

    run_search(0, 1'b0);
    es[0] = 64; es[1] = 64; es[2] = 64; es[3] = 64;
    check_results("after_abort", es, 64, 0, 37);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
